lsu_align: RTL and testbench
============================

# lsu_align

Sequential load/store alignment unit between the execute stage and a 32-bit word-addressed data memory. It accepts one load or store per handshake using the existing 3-bit load/store control encoding. It drives byte-lane enables and shifted write data, and handles word-crossing (misaligned) accesses by issuing two memory beats. Load data is merged and sign- or zero-extended before being returned as a single response.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of the request and memory ports.
- MISALIGN_EN, 1. Setting 1 splits word-crossing accesses into two beats. Setting 0 faults every non-naturally-aligned access.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready.
- req_ctrl  in  3  LB 000, LH 001, LW 010, LBU 011, LHU 100, SB 101, SH 110, SW 111.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte/half in low bits).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  misalignment fault, valid with rsp_valid.
- mem_valid  out  1  memory beat request.
- mem_ready  in  1  beat accepted when mem_valid & mem_ready.
- mem_we  out  1  1 = write beat.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-positioned write data.
- mem_rvalid  in  1  read data return, at least 1 cycle after read acceptance.
- mem_rdata  in  32  read data.

## Operation
- Access size: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW. off = addr[1:0].
- Crossing access: off+size > 4.
- With MISALIGN_EN=1, non-crossing accesses complete in one beat; crossing accesses take two beats.
- With MISALIGN_EN=0, an access faults when addr mod size ≠ 0. A fault issues no memory beat.
- Beat 1:
  - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - mem_be = (2^size−1) << off, truncated to 4 bits.
  - mem_wdata = wdata << 8·off.
- Beat 2:
  - mem_addr = beat-1 address + 4, wrapping modulo 2^ADDR_W.
  - mem_be = (2^size−1) >> (4−off).
  - mem_wdata = wdata >> 8·(4−off).
- Load merge: raw = (rdata1 >> 8·off) | (rdata2 << 8·(4−off)); the rdata2 term is used only when split.
- Load extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- FSM states: IDLE, B1_REQ, B1_WAIT, B2_REQ, B2_WAIT, RESP.
  - IDLE: on accept, latch request; go to RESP if faulting, else B1_REQ.
  - B1_REQ: on mem_ready, a store goes to B2_REQ if split, else RESP; a load goes to B1_WAIT.
  - B1_WAIT: on mem_rvalid, latch rdata1; go to B2_REQ if split, else RESP.
  - B2_REQ: on mem_ready, a store goes to RESP; a load goes to B2_WAIT.
  - B2_WAIT: on mem_rvalid, latch rdata2; go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- req_ready = (state==IDLE). mem_valid is high only in B1_REQ and B2_REQ.
- mem_rvalid is ignored outside B1_WAIT and B2_WAIT.
- Only one access is outstanding at any time.

## Timing
- Reset values: state IDLE, req_ready 1, and every other output 0 (rsp_valid, rsp_rdata, rsp_fault, mem_valid, mem_we, mem_addr, mem_be, mem_wdata). Internal latches are cleared.
- Reset mid-operation abandons the access immediately. No response is produced, and a late mem_rvalid after reset is ignored.
- While mem_valid=1 and mem_ready=0, mem_addr, mem_be, mem_wdata and mem_we hold stable.
- Latency from the request-accept edge to rsp_valid, with mem_ready=1 and mem_rvalid one cycle after acceptance:
  - fault: 1 cycle.
  - aligned store: 2 cycles.
  - aligned load: 3 cycles.
  - split store: 3 cycles.
  - split load: 5 cycles.
- Each mem_ready stall cycle or extra rvalid delay cycle adds one cycle.
- Back-to-back throughput: a new request can be accepted in the cycle after RESP.

## Test plan
- LW addr 0x100, mem returns 0x8899AABB, zero-wait memory -> one beat at 0x100 with be 1111; rsp_rdata 0x8899AABB, rsp_valid 3 cycles after accept.
- LB addr 0x103, rdata 0x80112233 -> be 1000, rsp_rdata 0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LH addr 0x203, MISALIGN_EN=1:
  - beat 1 at 0x200, be 1000, rdata 0xAB000000;
  - beat 2 at 0x204, be 0001, rdata 0x000000CD;
  - rsp_rdata 0xFFFFCDAB; repeat with LHU -> 0x0000CDAB.
- SW addr 0x106, wdata 0x11223344:
  - beat 1 at 0x104, be 1100, wdata 0x33440000;
  - beat 2 at 0x108, be 0011, wdata 0x00001122;
  - rsp_rdata 0.
- SH at 0xFFFFFFFF:
  - beat 2 mem_addr wraps to 0x00000000.
  - With MISALIGN_EN=0, LH addr 0x101 -> rsp_fault=1 one cycle after accept; mem_valid never asserts.
- Hold mem_ready low 3 cycles during beat 1 -> mem_* outputs stable throughout.
- Assert rst in B1_WAIT, then pulse mem_rvalid -> outputs at reset values, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu_align_if.sv
// Request/response channel plus memory beat channel of lsu_align.
// slave is the alignment unit's view; master is the requester/memory side.
interface lsu_align_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_ctrl;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_ctrl, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_ctrl, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: positions byte lanes, splits word-crossing
// accesses into two memory beats and merges/extends load data.
module lsu_align #(
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  lsu_align_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, B1_REQ, B1_WAIT, B2_REQ, B2_WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [2:0]        ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata1_q;
  logic [31:0]       rdata2_q;
  logic              fault_q;

  function automatic logic [2:0] size_of(input logic [2:0] ctrl);
    case (ctrl)
      3'b000, 3'b011, 3'b101: size_of = 3'd1;
      3'b001, 3'b100, 3'b110: size_of = 3'd2;
      default:                size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] size);
    case (size)
      3'd1:    mask_of = 4'b0001;
      3'd2:    mask_of = 4'b0011;
      default: mask_of = 4'b1111;
    endcase
  endfunction

  logic       accept;
  logic [2:0] req_size;
  logic [1:0] req_off;
  logic       req_fault;

  assign accept   = bus.req_valid && (state == IDLE);
  assign req_size = size_of(bus.req_ctrl);
  assign req_off  = bus.req_addr[1:0];
  assign req_fault = !MISALIGN_EN &&
                     (((req_size == 3'd2) && req_off[0]) ||
                      ((req_size == 3'd4) && (req_off != 2'b00)));

  logic [2:0]        size;
  logic [1:0]        off;
  logic [2:0]        end_pos;
  logic              split;
  logic              is_store;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        lane_mask;
  logic [63:0]       wide_wdata;
  logic [63:0]       wide_rdata;
  logic [31:0]       raw;
  logic [31:0]       load_data;

  assign size     = size_of(ctrl_q);
  assign off      = addr_q[1:0];
  assign end_pos  = {1'b0, off} + size;
  assign split    = MISALIGN_EN && (end_pos > 3'd4);
  assign is_store = ctrl_q[2] && (ctrl_q[1] || ctrl_q[0]);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Low half of each 64-bit shift feeds beat 1, high half feeds beat 2;
  // rdata2_q is zero for single-beat loads so the merge needs no mux.
  assign lane_mask  = {4'b0000, mask_of(size)} << off;
  assign wide_wdata = {32'd0, wdata_q} << {off, 3'b000};
  assign wide_rdata = {rdata2_q, rdata1_q} >> {off, 3'b000};
  assign raw        = wide_rdata[31:0];

  always_comb begin
    load_data = 32'd0;
    case (ctrl_q)
      3'b000:  load_data = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_data = {{16{raw[15]}}, raw[15:0]};
      3'b010:  load_data = raw;
      3'b011:  load_data = {24'd0, raw[7:0]};
      3'b100:  load_data = {16'd0, raw[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_fault ? RESP : B1_REQ;
      B1_REQ:  if (bus.mem_ready) state_next = is_store ? (split ? B2_REQ : RESP) : B1_WAIT;
      B1_WAIT: if (bus.mem_rvalid) state_next = split ? B2_REQ : RESP;
      B2_REQ:  if (bus.mem_ready) state_next = is_store ? RESP : B2_WAIT;
      B2_WAIT: if (bus.mem_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata1_q <= 32'd0;
      rdata2_q <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_q   <= bus.req_ctrl;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        fault_q  <= req_fault;
        rdata1_q <= 32'd0;
        rdata2_q <= 32'd0;
      end
      if ((state == B1_WAIT) && bus.mem_rvalid) rdata1_q <= bus.mem_rdata;
      if ((state == B2_WAIT) && bus.mem_rvalid) rdata2_q <= bus.mem_rdata;
    end
  end

  // Beat outputs come straight from latched request state, so they hold during stalls.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = 1'b0;
    bus.rsp_fault = 1'b0;
    bus.rsp_rdata = 32'd0;
    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = 4'd0;
    bus.mem_wdata = 32'd0;
    case (state)
      B1_REQ: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = is_store;
        bus.mem_addr  = word_addr;
        bus.mem_be    = lane_mask[3:0];
        bus.mem_wdata = wide_wdata[31:0];
      end
      B2_REQ: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = is_store;
        bus.mem_addr  = word_addr + ADDR_W'(4);
        bus.mem_be    = lane_mask[7:4];
        bus.mem_wdata = wide_wdata[63:32];
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_fault = fault_q;
        bus.rsp_rdata = fault_q ? 32'd0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed cases plus randomized traffic checked
// against a byte-addressed memory model.
module tb_lsu_align;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_align_if #(.ADDR_W(32)) bus_en ();
  lsu_align_if #(.ADDR_W(32)) bus_dis ();

  lsu_align #(.ADDR_W(32), .MISALIGN_EN(1'b1)) u_en  (.clk(clk), .rst(rst), .bus(bus_en.slave));
  lsu_align #(.ADDR_W(32), .MISALIGN_EN(1'b0)) u_dis (.clk(clk), .rst(rst), .bus(bus_dis.slave));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  dut_mem [bit [31:0]];
  logic [7:0]  ref_mem [bit [31:0]];
  beat_t       beat_q[$];
  int          stall_pct = 0;
  int          min_delay = 1;
  int          max_delay = 1;
  int          force_stall = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C ^ {a[2:0], a[31:27]};
  endfunction

  function automatic logic [7:0] dut_byte(input bit [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_byte(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic poke(input bit [31:0] a, input logic [7:0] v);
    dut_mem[a] = v;
    ref_mem[a] = v;
  endtask

  function automatic int ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [31:0] raw);
    case (ctrl)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd2:    return raw;
      3'd3:    return {24'd0, raw[7:0]};
      3'd4:    return {16'd0, raw[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // Memory for the split-capable unit: random ready stalls, random read latency.
  initial begin : mem_responder
    int          cnt;
    int          held;
    bit          was_stalled;
    logic [31:0] rd;
    beat_t       last;
    cnt = 0;
    held = 0;
    was_stalled = 1'b0;
    rd = 32'd0;
    last = '0;
    bus_en.mem_ready  = 1'b0;
    bus_en.mem_rvalid = 1'b0;
    bus_en.mem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      bus_en.mem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus_en.mem_rvalid = 1'b1;
          bus_en.mem_rdata  = rd;
        end
      end
      if (was_stalled && bus_en.mem_valid) begin
        checkOutput("stall_addr",  bus_en.mem_addr, last.addr);
        checkOutput("stall_be",    32'(bus_en.mem_be), 32'(last.be));
        checkOutput("stall_wdata", bus_en.mem_wdata, last.wdata);
        checkOutput("stall_we",    32'(bus_en.mem_we), 32'(last.we));
      end
      if (bus_en.mem_valid) begin
        if (held < force_stall) begin
          bus_en.mem_ready = 1'b0;
          held++;
        end else begin
          bus_en.mem_ready = ($urandom_range(99) >= stall_pct);
        end
      end else begin
        bus_en.mem_ready = 1'b0;
      end
      was_stalled = bus_en.mem_valid && !bus_en.mem_ready;
      last.we    = bus_en.mem_we;
      last.addr  = bus_en.mem_addr;
      last.be    = bus_en.mem_be;
      last.wdata = bus_en.mem_wdata;
      if (bus_en.mem_valid && bus_en.mem_ready) begin
        held = 0;
        beat_q.push_back(last);
        if (last.we) begin
          for (int i = 0; i < 4; i++)
            if (last.be[i]) dut_mem[last.addr + 32'(i)] = last.wdata[8*i +: 8];
        end else begin
          for (int i = 0; i < 4; i++) rd[8*i +: 8] = dut_byte(last.addr + 32'(i));
          cnt = int'($urandom_range(max_delay, min_delay));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic fault, output int lat);
    beat_q.delete();
    @(negedge clk);
    checkOutput("req_ready", 32'(bus_en.req_ready), 32'd1);
    checkOutput("rsp_pulse", 32'(bus_en.rsp_valid), 32'd0);
    bus_en.req_valid = 1'b1;
    bus_en.req_ctrl  = ctrl;
    bus_en.req_addr  = addr;
    bus_en.req_wdata = wdata;
    @(posedge clk);
    #1 bus_en.req_valid = 1'b0;
    lat = 0;
    rdata = 32'd0;
    fault = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus_en.rsp_valid) begin
        rdata = bus_en.rsp_rdata;
        fault = bus_en.rsp_fault;
        break;
      end
      if (lat >= 200) begin
        checkOutput("rsp_timeout", 32'(lat), 32'd0);
        break;
      end
    end
  endtask

  // Reference: byte-wise view of memory; stores update bytes, loads gather them.
  task automatic run_checked(input logic [2:0] ctrl, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    int          size;
    int          off;
    bit          split;
    bit          store;
    logic [31:0] raw;
    logic [31:0] exp;
    logic [31:0] got_bytes;
    logic [31:0] exp_bytes;
    logic        fault;
    size  = ctrl_size(ctrl);
    off   = int'(addr[1:0]);
    split = (off + size) > 4;
    store = (ctrl >= 3'd5);
    raw   = 32'd0;
    for (int i = 0; i < size; i++) raw |= 32'(ref_byte(addr + 32'(i))) << (8 * i);
    exp = store ? 32'd0 : extend(ctrl, raw);
    applyStimulus(ctrl, addr, wdata, rdata, fault, lat);
    checkOutput("rsp_rdata", rdata, exp);
    checkOutput("rsp_fault", 32'(fault), 32'd0);
    checkOutput("beat_count", 32'(beat_q.size()), split ? 32'd2 : 32'd1);
    if (store) begin
      got_bytes = 32'd0;
      exp_bytes = 32'd0;
      for (int i = 0; i < size; i++) begin
        ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        got_bytes |= 32'(dut_byte(addr + 32'(i))) << (8 * i);
        exp_bytes |= 32'(ref_byte(addr + 32'(i))) << (8 * i);
      end
      checkOutput("store_bytes", got_bytes, exp_bytes);
    end
    if (stall_pct == 0 && force_stall == 0 && max_delay == 1)
      checkOutput("latency", 32'(lat), store ? (split ? 32'd3 : 32'd2) : (split ? 32'd5 : 32'd3));
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
    if (beat_q.size() > idx) begin
      checkOutput({tag, "_addr"}, beat_q[idx].addr, addr);
      checkOutput({tag, "_be"}, 32'(beat_q[idx].be), 32'(be));
      if (beat_q[idx].we) checkOutput({tag, "_wdata"}, beat_q[idx].wdata, wdata);
    end else begin
      checkOutput({tag, "_missing"}, 32'(beat_q.size()), 32'(idx + 1));
    end
  endtask

  // Strict-alignment unit: ready always high, read data one cycle after a read beat.
  task automatic run_dis(input logic [2:0] ctrl, input logic [31:0] addr);
    int          size;
    int          off;
    bit          exp_fault;
    bit          saw_mem;
    bit          pend;
    int          lat;
    logic [31:0] word;
    logic [31:0] raw;
    logic [31:0] exp;
    logic [31:0] rdata;
    logic        fault;
    size = ctrl_size(ctrl);
    off  = int'(addr[1:0]);
    exp_fault = (off % size) != 0;
    word = 32'h8899AABB;
    raw  = 32'd0;
    for (int i = 0; i < size && (off + i) < 4; i++) raw |= 32'(word[8*(off+i) +: 8]) << (8 * i);
    exp = exp_fault ? 32'd0 : extend(ctrl, raw);
    @(negedge clk);
    bus_dis.req_valid = 1'b1;
    bus_dis.req_ctrl  = ctrl;
    bus_dis.req_addr  = addr;
    bus_dis.req_wdata = $urandom;
    @(posedge clk);
    #1 bus_dis.req_valid = 1'b0;
    saw_mem = 1'b0;
    pend = 1'b0;
    lat = 0;
    rdata = 32'd0;
    fault = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      bus_dis.mem_rvalid = pend;
      pend = bus_dis.mem_valid && !bus_dis.mem_we;
      if (bus_dis.mem_valid) saw_mem = 1'b1;
      if (bus_dis.rsp_valid) begin
        rdata = bus_dis.rsp_rdata;
        fault = bus_dis.rsp_fault;
        break;
      end
      if (lat >= 20) begin
        checkOutput("dis_timeout", 32'(lat), 32'd0);
        break;
      end
    end
    bus_dis.mem_rvalid = 1'b0;
    checkOutput("dis_fault", 32'(fault), 32'(exp_fault));
    checkOutput("dis_rdata", rdata, exp);
    if (exp_fault) begin
      checkOutput("dis_fault_latency", 32'(lat), 32'd1);
      checkOutput("dis_fault_no_mem", 32'(saw_mem), 32'd0);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] ready_exp);
    checkOutput({tag, "_req_ready"}, 32'(bus_en.req_ready), ready_exp);
    checkOutput({tag, "_rsp_valid"}, 32'(bus_en.rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, bus_en.rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_fault"}, 32'(bus_en.rsp_fault), 32'd0);
    checkOutput({tag, "_mem_valid"}, 32'(bus_en.mem_valid), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(bus_en.mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, bus_en.mem_addr, 32'd0);
    checkOutput({tag, "_mem_be"}, 32'(bus_en.mem_be), 32'd0);
    checkOutput({tag, "_mem_wdata"}, bus_en.mem_wdata, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rdata;
    int          lat;
    int          seen_rsp;
    int          seen_mem;
    logic [2:0]  ctrl;
    logic [31:0] addr;

    rst = 1'b1;
    bus_en.req_valid  = 1'b0;
    bus_en.req_ctrl   = 3'd0;
    bus_en.req_addr   = 32'd0;
    bus_en.req_wdata  = 32'd0;
    bus_dis.req_valid = 1'b0;
    bus_dis.req_ctrl  = 3'd0;
    bus_dis.req_addr  = 32'd0;
    bus_dis.req_wdata = 32'd0;
    bus_dis.mem_ready = 1'b1;
    bus_dis.mem_rvalid = 1'b0;
    bus_dis.mem_rdata = 32'h8899AABB;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset", 32'd1);
    rst = 1'b0;

    poke(32'h100, 8'hBB); poke(32'h101, 8'hAA); poke(32'h102, 8'h99); poke(32'h103, 8'h88);
    run_checked(3'd2, 32'h100, 32'd0, rdata, lat);
    checkOutput("lw_rdata", rdata, 32'h8899AABB);
    checkOutput("lw_latency", 32'(lat), 32'd3);
    check_beat("lw_b1", 0, 32'h100, 4'b1111, 32'd0);

    poke(32'h100, 8'h33); poke(32'h101, 8'h22); poke(32'h102, 8'h11); poke(32'h103, 8'h80);
    run_checked(3'd0, 32'h103, 32'd0, rdata, lat);
    checkOutput("lb_rdata", rdata, 32'hFFFFFF80);
    check_beat("lb_b1", 0, 32'h100, 4'b1000, 32'd0);
    run_checked(3'd3, 32'h103, 32'd0, rdata, lat);
    checkOutput("lbu_rdata", rdata, 32'h00000080);

    for (int i = 0; i < 8; i++) poke(32'h200 + 32'(i), 8'h00);
    poke(32'h203, 8'hAB);
    poke(32'h204, 8'hCD);
    run_checked(3'd1, 32'h203, 32'd0, rdata, lat);
    checkOutput("lh_rdata", rdata, 32'hFFFFCDAB);
    checkOutput("lh_latency", 32'(lat), 32'd5);
    check_beat("lh_b1", 0, 32'h200, 4'b1000, 32'd0);
    check_beat("lh_b2", 1, 32'h204, 4'b0001, 32'd0);
    run_checked(3'd4, 32'h203, 32'd0, rdata, lat);
    checkOutput("lhu_rdata", rdata, 32'h0000CDAB);

    run_checked(3'd7, 32'h106, 32'h11223344, rdata, lat);
    checkOutput("sw_rdata", rdata, 32'd0);
    checkOutput("sw_latency", 32'(lat), 32'd3);
    check_beat("sw_b1", 0, 32'h104, 4'b1100, 32'h33440000);
    check_beat("sw_b2", 1, 32'h108, 4'b0011, 32'h00001122);

    run_checked(3'd6, 32'hFFFFFFFF, 32'h0000BEEF, rdata, lat);
    check_beat("sh_wrap_b1", 0, 32'hFFFFFFFC, 4'b1000, 32'hEF000000);
    check_beat("sh_wrap_b2", 1, 32'h00000000, 4'b0001, 32'h000000BE);

    run_checked(3'd5, 32'h101, 32'h000000A5, rdata, lat);
    checkOutput("sb_latency", 32'(lat), 32'd2);
    check_beat("sb_b1", 0, 32'h100, 4'b0010, 32'h0000A500);

    force_stall = 3;
    run_checked(3'd2, 32'h120, 32'd0, rdata, lat);
    checkOutput("stall_latency", 32'(lat), 32'd6);
    force_stall = 0;

    stall_pct = 30;
    max_delay = 3;
    for (int n = 0; n < 150; n++) begin
      ctrl = 3'($urandom_range(7));
      if ($urandom_range(3) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(7));
      else                        addr = 32'h100 + 32'($urandom_range(63));
      run_checked(ctrl, addr, $urandom, rdata, lat);
    end

    // Reset while waiting for read data; the late rvalid must be ignored.
    stall_pct = 0;
    min_delay = 4;
    max_delay = 4;
    @(negedge clk);
    bus_en.req_valid = 1'b1;
    bus_en.req_ctrl  = 3'd2;
    bus_en.req_addr  = 32'h100;
    @(posedge clk);
    #1 bus_en.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset", 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen_rsp = 0;
    seen_mem = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_en.rsp_valid) seen_rsp++;
      if (bus_en.mem_valid) seen_mem++;
    end
    checkOutput("midreset_no_rsp", 32'(seen_rsp), 32'd0);
    checkOutput("midreset_no_mem", 32'(seen_mem), 32'd0);
    check_idle_outputs("after_reset", 32'd1);
    min_delay = 1;
    max_delay = 1;
    run_checked(3'd2, 32'h104, 32'd0, rdata, lat);

    run_dis(3'd1, 32'h101);
    for (int c = 0; c < 8; c++)
      for (int o = 0; o < 4; o++)
        run_dis(3'(c), 32'h100 + 32'(o));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
